// File: rtl/line_buffer_3row_if.sv
// Pixel-in / column-out bundle for line_buffer_3row.
// DATA_WIDTH defaults to 8 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface line_buffer_3row_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int COL_W      = 5
);
  logic                         in_valid;
  logic                         in_sof;
  logic signed [DATA_WIDTH-1:0] in_px;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] row0_px;
  logic signed [DATA_WIDTH-1:0] row1_px;
  logic signed [DATA_WIDTH-1:0] row2_px;
  logic [COL_W-1:0]             out_col;
  logic                         out_last_col;
  logic                         frame_done;

  modport master (
    output in_valid, in_sof, in_px,
    input  out_valid, row0_px, row1_px, row2_px,
    input  out_col, out_last_col, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_px,
    output out_valid, row0_px, row1_px, row2_px,
    output out_col, out_last_col, frame_done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Raster pixel stream to 3-pixel vertical columns via two line memories.
// Optional LB_TOP_PAD_EN: zero rows above the image, output from row 0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module line_buffer_3row #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input logic             clk,
  input logic             reset,
  line_buffer_3row_if.slave bus
);

  typedef enum logic [1:0] {
    S_FILL0,
    S_FILL1,
    S_STREAM
  } state_t;

`ifdef LB_TOP_PAD_EN
  localparam state_t S_START = S_STREAM;
`else
  localparam state_t S_START = S_FILL0;
`endif

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  state_t state;
  state_t s_eff;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] c_eff;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] r_eff;

  logic signed [DATA_WIDTH-1:0] line0 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] rd0;
  logic signed [DATA_WIDTH-1:0] rd1;
  logic signed [DATA_WIDTH-1:0] m0;
  logic signed [DATA_WIDTH-1:0] m1;

  logic last_col;
  logic last_row;
  logic stream;

  logic                         valid_q;
  logic signed [DATA_WIDTH-1:0] r0_q;
  logic signed [DATA_WIDTH-1:0] r1_q;
  logic signed [DATA_WIDTH-1:0] r2_q;
  logic [COL_W-1:0]             col_q;
  logic                         last_q;
  logic                         done_q;

  // A sof pixel is processed as (row 0, col 0) in the start state.
  always_comb begin
    c_eff    = bus.in_sof ? '0 : col;
    r_eff    = bus.in_sof ? '0 : row;
    s_eff    = bus.in_sof ? S_START : state;
    rd0      = line0[c_eff];
    rd1      = line1[c_eff];
    last_col = (c_eff == LAST_COL);
    last_row = (r_eff == LAST_ROW);
    stream   = (s_eff == S_STREAM);
  end

`ifdef LB_TOP_PAD_EN
  always_comb begin
    m0 = (r_eff < ROW_W'(2)) ? '0 : rd0;
    m1 = (r_eff == '0)       ? '0 : rd1;
  end
`else
  always_comb begin
    m0 = rd0;
    m1 = rd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset && bus.in_valid) begin
      line0[c_eff] <= rd1;
      line1[c_eff] <= bus.in_px;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_START;
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.in_valid) begin
      valid_q <= stream;
      r0_q    <= m0;
      r1_q    <= m1;
      r2_q    <= bus.in_px;
      col_q   <= c_eff;
      last_q  <= stream && last_col;
      done_q  <= stream && last_col && last_row;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : r_eff + 1'b1;
        case (s_eff)
          S_FILL0: state <= S_FILL1;
          S_FILL1: state <= S_STREAM;
          default: state <= last_row ? S_START : S_STREAM;
        endcase
      end else begin
        col   <= c_eff + 1'b1;
        row   <= r_eff;
        state <= s_eff;
      end
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.row0_px      = r0_q;
  assign bus.row1_px      = r1_q;
  assign bus.row2_px      = r2_q;
  assign bus.out_col      = col_q;
  assign bus.out_last_col = last_q;
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row on a 4x4 image with an image-array model.
// Build with LB_TOP_PAD_EN to exercise the top-padding variant.
`timescale 1ns/1ps

module tb_line_buffer_3row;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [28:0] ALL = 29'h1FFFFFFF;
  localparam logic [28:0] CTL = 29'h1000000F;

  logic clk = 1'b0;
  logic reset;

  line_buffer_3row_if #(.DATA_WIDTH(8), .COL_W(2)) bus ();

  line_buffer_3row #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: position within frame plus the frame pixels seen so far
  int          p;
  logic [7:0]  img [H][W];
  logic        e_v, e_last, e_done, known;
  logic [7:0]  e_r0, e_r1, e_r2;
  logic [1:0]  e_col;
  logic [28:0] expv, obs, dm;

  task automatic model(input bit rst, input bit v, input bit sof,
                       input logic [7:0] px);
    int r, c;
    if (rst) begin
      p = 0; e_v = 0; e_r0 = 0; e_r1 = 0; e_r2 = 0;
      e_col = 0; e_last = 0; e_done = 0; known = 1;
    end else if (!v) begin
      e_v = 0; e_last = 0; e_done = 0;
    end else begin
      if (sof) p = 0;
      r = p / W;
      c = p % W;
      img[r][c] = px;
`ifdef LB_TOP_PAD_EN
      e_v  = 1;
      e_r0 = 0;
      e_r1 = 0;
      if (r >= 2) e_r0 = img[r-2][c];
      if (r >= 1) e_r1 = img[r-1][c];
      known = 1;
`else
      e_v = (r >= 2);
      if (e_v) begin
        e_r0 = img[r-2][c];
        e_r1 = img[r-1][c];
      end
      known = e_v;
`endif
      e_r2   = px;
      e_col  = 2'(c);
      e_last = e_v && (c == W - 1);
      e_done = e_v && (p == W * H - 1);
      p = (p + 1) % (W * H);
    end
    expv = {e_v, e_r0, e_r1, e_r2, e_col, e_last, e_done};
    dm   = known ? ALL : CTL;
  endtask

  task automatic step(input bit rst, input bit v, input bit sof,
                      input logic [7:0] px);
    reset        = rst;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_px    = px;
    model(rst, v, sof, px);
    @(posedge clk);
    #1;
    obs = {bus.out_valid, bus.row0_px, bus.row1_px, bus.row2_px,
           bus.out_col, bus.out_last_col, bus.frame_done};
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h55);
    n_tests++;
    if (obs !== 29'h0) begin
      n_fail++;
      $display("FAIL reset obs=%h exp=%h", obs, 29'h0);
    end
  endtask

  task automatic test_continuous();
    int ncols = 0;
    logic [23:0] first = '1;
    logic [23:0] donec = '0;
    for (int i = 0; i < W * H; i++) begin
      step(0, 1, i == 0, 8'(16 * (i / W) + (i % W)));
      n_tests++;
      if ((obs & dm) !== (expv & dm)) begin
        n_fail++;
        $display("FAIL continuous[%0d] obs=%h exp=%h", i, obs & dm, expv & dm);
      end
      if (bus.out_valid) begin
        if (ncols == 0) first = {bus.row0_px, bus.row1_px, bus.row2_px};
        ncols++;
      end
      if (bus.frame_done) donec = {bus.row0_px, bus.row1_px, bus.row2_px};
    end
`ifdef LB_TOP_PAD_EN
    n_tests++;
    if (ncols !== 16) begin
      n_fail++;
      $display("FAIL cont_count obs=%0d exp=16", ncols);
    end
    n_tests++;
    if (first !== 24'h000000) begin
      n_fail++;
      $display("FAIL cont_first obs=%h exp=000000", first);
    end
`else
    n_tests++;
    if (ncols !== 8) begin
      n_fail++;
      $display("FAIL cont_count obs=%0d exp=8", ncols);
    end
    n_tests++;
    if (first !== 24'h001020) begin
      n_fail++;
      $display("FAIL cont_first obs=%h exp=001020", first);
    end
`endif
    n_tests++;
    if (donec !== 24'h132333) begin
      n_fail++;
      $display("FAIL cont_done obs=%h exp=132333", donec);
    end
  endtask

  task automatic test_gaps();
    int i = 0;
    while (i < W * H) begin
      if ($urandom_range(0, 1) == 0) begin
        step(0, 0, 0, 8'($urandom));
      end else begin
        step(0, 1, i == 0, 8'(16 * (i / W) + (i % W)));
        i++;
      end
      n_tests++;
      if ((obs & dm) !== (expv & dm)) begin
        n_fail++;
        $display("FAIL gaps[%0d] obs=%h exp=%h", i, obs & dm, expv & dm);
      end
    end
  endtask

  task automatic test_sof_resync();
    for (int i = 0; i < 13 + W * H; i++) begin
      if (i < 13) step(0, 1, i == 0, 8'(16 * (i / W) + (i % W)));
      else        step(0, 1, i == 13, 8'($urandom));
      n_tests++;
      if ((obs & dm) !== (expv & dm)) begin
        n_fail++;
        $display("FAIL sof[%0d] obs=%h exp=%h", i, obs & dm, expv & dm);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++)
      step(0, 1, i == 0, 8'(16 * (i / W) + (i % W)));
    step(1, 1, 0, 8'h22);
    n_tests++;
    if (obs !== 29'h0) begin
      n_fail++;
      $display("FAIL reset_mid obs=%h exp=%h", obs, 29'h0);
    end
    for (int i = 0; i < W * H; i++) begin
      step(0, 1, 0, 8'(16 * (i / W) + (i % W)));
      n_tests++;
      if ((obs & dm) !== (expv & dm)) begin
        n_fail++;
        $display("FAIL after_reset[%0d] obs=%h exp=%h", i, obs & dm, expv & dm);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3 * W * H; i++) begin
      step(0, 1, i == 2 * W * H, 8'($urandom));
      n_tests++;
      if ((obs & dm) !== (expv & dm)) begin
        n_fail++;
        $display("FAIL b2b[%0d] obs=%h exp=%h", i, obs & dm, expv & dm);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 4,
           8'($urandom));
      n_tests++;
      if ((obs & dm) !== (expv & dm)) begin
        n_fail++;
        $display("FAIL random[%0d] obs=%h exp=%h", i, obs & dm, expv & dm);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_px    = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_sof_resync();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
